sys_mm_engine: RTL

SYS_MM_ENGINE -- requirements
Module: sys_mm_engine

---
 rtl/sys_mm_pkg.sv | 16 +
 rtl/sys_mm_pe.sv | 57 +++++
 rtl/sys_mm_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sys_mm_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
package sys_mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Cycles needed for the last operand pair to reach PE(S-1,S-1).
    function automatic int unsigned run_len(input int unsigned s);
        return 3 * s - 2;
    endfunction

endpackage

// File: rtl/sys_mm_pe.sv
// Systolic processing element: wrapping MAC plus one-cycle a/b forwarding.
module sys_mm_pe #(
    parameter int unsigned N = 2,
    parameter int unsigned M = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [M-1:0] c_nxt_c,
    output logic         ovf_c
);
    localparam int unsigned PW = 2 * N;
    localparam int unsigned SW = ((PW > M) ? PW : M) + 1;

    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [M-1:0]  c_q, c_d;
    logic [PW-1:0] prod;
    logic [SW-1:0] sum;

    // Full-width sum so any bit above M flags a wrap.
    always_comb begin
        a_d   = a_i;
        b_d   = b_i;
        prod  = PW'(a_i) * PW'(b_i);
        sum   = SW'(c_q) + SW'(prod);
        c_d   = c_q;
        ovf_c = 1'b0;
        if (clr) begin
            c_d = '0;
        end else if (en) begin
            c_d   = sum[M-1:0];
            ovf_c = |sum[SW-1:M];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign c_nxt_c = c_d;

endmodule

// File: rtl/sys_mm_engine.sv
// SxS output-stationary systolic multiplier with bank select and accumulate mode.
module sys_mm_engine
    import sys_mm_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned S = 4,
    parameter int unsigned M = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [S*S*N-1:0] A1,
    input  logic [S*S*N-1:0] A2,
    input  logic [S*S*N-1:0] B1,
    input  logic [S*S*N-1:0] B2,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             acc,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [S*S*M-1:0] Data
);
    localparam int unsigned D  = 2 * S - 1;
    localparam int unsigned RL = run_len(S);
    localparam int unsigned CW = $clog2(RL);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accm_q, accm_d;
    logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [S*S*M-1:0] data_q, data_d;
    logic [N-1:0]     sa_q [S][D];
    logic [N-1:0]     sa_d [S][D];
    logic [N-1:0]     sb_q [S][D];
    logic [N-1:0]     sb_d [S][D];
    logic [N-1:0]     a_edge [S];
    logic [N-1:0]     b_edge [S];
    logic [N-1:0]     a_fwd [S][S];
    logic [N-1:0]     b_fwd [S][S];
    logic [M-1:0]     c_nxt [S][S];
    logic [S*S-1:0]   pe_ovf;
    logic [S*S*N-1:0] a_sel, b_sel;
    logic             accept, run, clr;

    assign accept = (state_q == ST_IDLE) && start;
    assign run    = (state_q == ST_RUN);
    assign clr    = (state_q == ST_LOAD) && !accm_q;
    assign a_sel  = sel1 ? A2 : A1;
    assign b_sel  = sel2 ? B2 : B1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accm_d  = accm_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_LOAD;
                accm_d  = acc;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RL - 1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Skew lines: row r / column c are preloaded with r / c leading zeros, then shifted in RUN.
    always_comb begin
        sa_d = sa_q;
        sb_d = sb_q;
        if (accept) begin
            for (int i = 0; i < S; i++) begin
                for (int j = 0; j < D; j++) begin
                    sa_d[i][j] = '0;
                    sb_d[i][j] = '0;
                    if (j >= i && j < i + S) begin
                        sa_d[i][j] = a_sel[(S*S-1-(i*S+(j-i)))*N +: N];
                        sb_d[i][j] = b_sel[(S*S-1-((j-i)*S+i))*N +: N];
                    end
                end
            end
        end else if (run) begin
            for (int i = 0; i < S; i++) begin
                for (int j = 0; j < D - 1; j++) begin
                    sa_d[i][j] = sa_q[i][j+1];
                    sb_d[i][j] = sb_q[i][j+1];
                end
                sa_d[i][D-1] = '0;
                sb_d[i][D-1] = '0;
            end
        end
        for (int i = 0; i < S; i++) begin
            a_edge[i] = run ? sa_q[i][0] : '0;
            b_edge[i] = run ? sb_q[i][0] : '0;
        end
    end

    always_comb begin
        ovf_d  = ovf_q;
        data_d = data_q;
        if (clr) ovf_d = 1'b0;
        else if (run) ovf_d = ovf_q | (|pe_ovf);
        if (run && state_d == ST_DONE) begin
            for (int r = 0; r < S; r++) begin
                for (int c = 0; c < S; c++) begin
                    data_d[(S*S-1-(r*S+c))*M +: M] = c_nxt[r][c];
                end
            end
        end
    end

    for (genvar r = 0; r < S; r++) begin : g_row
        for (genvar c = 0; c < S; c++) begin : g_col
            logic [N-1:0] a_in, b_in;
            if (c == 0) begin : g_al
                assign a_in = a_edge[r];
            end else begin : g_ai
                assign a_in = a_fwd[r][c-1];
            end
            if (r == 0) begin : g_bt
                assign b_in = b_edge[c];
            end else begin : g_bi
                assign b_in = b_fwd[r-1][c];
            end
            sys_mm_pe #(.N(N), .M(M)) u_pe (
                .clk     (clk),
                .rst     (rst),
                .en      (run),
                .clr     (clr),
                .a_i     (a_in),
                .b_i     (b_in),
                .a_o     (a_fwd[r][c]),
                .b_o     (b_fwd[r][c]),
                .c_nxt_c (c_nxt[r][c]),
                .ovf_c   (pe_ovf[r*S+c])
            );
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            accm_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            for (int i = 0; i < S; i++) begin
                for (int j = 0; j < D; j++) begin
                    sa_q[i][j] <= '0;
                    sb_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            accm_q  <= accm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign Data = data_q;

endmodule
